// File: rtl/rgb_pixel_serializer.sv
// rgb_pixel_serializer
//   Producer side of the grayscale converter's channel-serial input protocol.
//   Accepts one packed {R,G,B} pixel per valid/ready handshake, then emits a
//   one-cycle start pulse, an optional gap, and R, G, B on consecutive cycles
//   on a zero-extended serial colour bus. Optionally holds off the next pixel
//   until the converter reports a result (or a timeout expires).
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   pix_valid_i  upstream pixel valid
//   pix_data_i   packed pixel {R,G,B}, R in the MSBs
//   pix_ready_o  upstream ready (high only in IDLE)
//   start_o      one-cycle start pulse to the converter
//   RgbColor_o   serial channel value (0 outside the R/G/B cycles)
//   dn_valid_i   converter result valid (only observed in SEND_B and WAIT)
//   busy_o       high in every state except IDLE
//   timeout_o    one-cycle pulse when the WAIT timeout expires
//   px_count_o   pixels completed (done or timed out), wrapping
module rgb_pixel_serializer #(
  parameter int unsigned CHAN_W     = 8,
  parameter int unsigned OUT_W      = 10,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned WAIT_DONE  = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pix_valid_i,
  input  logic [3*CHAN_W-1:0]   pix_data_i,
  output logic                  pix_ready_o,
  output logic                  start_o,
  output logic [OUT_W-1:0]      RgbColor_o,
  input  logic                  dn_valid_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [15:0]           px_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_SEND_R, S_SEND_G, S_SEND_B, S_WAIT
  } state_t;

  localparam logic [3:0]  GAP_N = 4'(GAP_CYCLES);
  localparam logic [15:0] TO_N  = 16'(TIMEOUT);

  state_t                state_q, state_d;
  logic [3*CHAN_W-1:0]   pix_q, pix_d;
  logic [3:0]            gap_q, gap_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  tout_q, tout_d;
  logic [OUT_W-1:0]      rgb_q, rgb_d;

  logic [CHAN_W-1:0]     ch_r, ch_g, ch_b;

  assign ch_r = pix_q[3*CHAN_W-1:2*CHAN_W];
  assign ch_g = pix_q[2*CHAN_W-1:CHAN_W];
  assign ch_b = pix_q[CHAN_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      gap_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      gap_q   <= gap_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
      rgb_q   <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    gap_d   = gap_q;
    wcnt_d  = wcnt_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Handshake uses the registered ready, so nothing is taken in the
        // first cycle after reset release.
        if (pix_valid_i && ready_q) begin
          pix_d   = pix_data_i;
          gap_d   = '0;
          wcnt_d  = '0;
          done_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: state_d = (GAP_CYCLES == 0) ? S_SEND_R : S_GAP;
      S_GAP: begin
        if (gap_q + 4'd1 == GAP_N) state_d = S_SEND_R;
        else                        gap_d   = gap_q + 4'd1;
      end
      S_SEND_R: state_d = S_SEND_G;
      S_SEND_G: state_d = S_SEND_B;
      S_SEND_B: begin
        // Remember an early result so a fast converter is not missed.
        if (dn_valid_i) done_d = 1'b1;
        if (WAIT_DONE != 0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (done_q || dn_valid_i) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
          if (wcnt_d == TO_N) begin
            state_d = S_IDLE;
            tout_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d = (state_d == S_IDLE);
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    rgb_d   = '0;
    case (state_d)
      S_SEND_R: rgb_d = OUT_W'(ch_r);
      S_SEND_G: rgb_d = OUT_W'(ch_g);
      S_SEND_B: rgb_d = OUT_W'(ch_b);
      default:  rgb_d = '0;
    endcase
  end

  assign pix_ready_o = ready_q;
  assign start_o     = start_q;
  assign RgbColor_o  = rgb_q;
  assign busy_o      = busy_q;
  assign timeout_o   = tout_q;
  assign px_count_o  = cnt_q;

endmodule

// File: tb/tb_rgb_pixel_serializer.sv
// Bench for rgb_pixel_serializer. Three instances cover the default setup,
// GAP_CYCLES=0/WAIT_DONE=0, and TIMEOUT=4. Expected channel values are queued
// when a pixel is offered and popped in the cycles where R/G/B must appear.
module tb_rgb_pixel_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid;
  logic [2:0]  dn;
  logic [23:0] pix [3];
  wire  [2:0]  ready, start, busy, tout;
  wire  [9:0]  rgb [3];
  wire  [15:0] px  [3];

  int          n_asrt = 0;
  int          n_fail = 0;
  int          tout_cnt [3] = '{0, 0, 0};
  logic [9:0]  sbq [$];
  logic [23:0] plist [3] = '{24'hFF0080, 24'h010203, 24'h7F80FE};

  always #5 clk = ~clk;

  rgb_pixel_serializer u_def (
    .clk_i(clk), .rst_i(rst), .pix_valid_i(valid[0]), .pix_data_i(pix[0]),
    .pix_ready_o(ready[0]), .start_o(start[0]), .RgbColor_o(rgb[0]),
    .dn_valid_i(dn[0]), .busy_o(busy[0]), .timeout_o(tout[0]), .px_count_o(px[0])
  );

  rgb_pixel_serializer #(.GAP_CYCLES(0), .WAIT_DONE(0)) u_nowait (
    .clk_i(clk), .rst_i(rst), .pix_valid_i(valid[1]), .pix_data_i(pix[1]),
    .pix_ready_o(ready[1]), .start_o(start[1]), .RgbColor_o(rgb[1]),
    .dn_valid_i(dn[1]), .busy_o(busy[1]), .timeout_o(tout[1]), .px_count_o(px[1])
  );

  rgb_pixel_serializer #(.TIMEOUT(4)) u_to4 (
    .clk_i(clk), .rst_i(rst), .pix_valid_i(valid[2]), .pix_data_i(pix[2]),
    .pix_ready_o(ready[2]), .start_o(start[2]), .RgbColor_o(rgb[2]),
    .dn_valid_i(dn[2]), .busy_o(busy[2]), .timeout_o(tout[2]), .px_count_o(px[2])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (tout[d] === 1'b1) tout_cnt[d]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [23:0] p);
    pix[d]   = p;
    valid[d] = 1'b1;
    sbq.push_back({2'b00, p[23:16]});
    sbq.push_back({2'b00, p[15:8]});
    sbq.push_back({2'b00, p[7:0]});
  endtask

  // Entered in the START cycle; leaves in the SEND_B cycle. dn is raised
  // only in cycle dn_cyc (0 = START); churn scrambles the pixel input.
  task automatic watch(input int d, input int gap, input int dn_cyc, input bit churn);
    logic [9:0] e;
    for (int i = 0; i < gap + 4; i++) begin
      if (i > 0) tick();
      dn[d] = (i == dn_cyc);
      if (churn) pix[d] = 24'($urandom);
      chk($sformatf("start%0d_c%0d", d, i), start[d], (i == 0));
      chk($sformatf("busy%0d_c%0d", d, i), busy[d], 1);
      chk($sformatf("ready%0d_c%0d", d, i), ready[d], 0);
      if (i < gap + 1) begin
        chk($sformatf("rgb%0d_zero_c%0d", d, i), rgb[d], 0);
      end else begin
        n_asrt++;
        assert (sbq.size() != 0)
        else begin
          n_fail++;
          $error("FAIL sb_empty%0d: observed 0 entries expected >0", d);
        end
        e = (sbq.size() != 0) ? sbq.pop_front() : 10'h3FF;
        chk($sformatf("rgb%0d_chan_c%0d", d, i), rgb[d], e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    valid = '0;
    dn    = '0;
    for (int d = 0; d < 3; d++) pix[d] = '0;

    // Reset state
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready%0d", d), ready[d], 0);
      chk($sformatf("rst_start%0d", d), start[d], 0);
      chk($sformatf("rst_rgb%0d", d), rgb[d], 0);
      chk($sformatf("rst_busy%0d", d), busy[d], 0);
      chk($sformatf("rst_tout%0d", d), tout[d], 0);
      chk($sformatf("rst_px%0d", d), px[d], 0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_ready%0d", d), ready[d], 1);
      chk($sformatf("post_rst_busy%0d", d), busy[d], 0);
    end

    // Defaults: 0xEEEEEE, done raised in cycle k+8
    send(0, 24'hEEEEEE);
    tick();
    valid[0] = 1'b0;
    watch(0, 1, -1, 0);
    tick();
    chk("def_wait_busy", busy[0], 1);
    chk("def_wait_rgb", rgb[0], 0);
    chk("def_wait_start", start[0], 0);
    tick();
    chk("def_wait2_busy", busy[0], 1);
    tick();
    dn[0] = 1'b1;
    tick();
    dn[0] = 1'b0;
    chk("def_done_busy", busy[0], 0);
    chk("def_done_ready", ready[0], 1);
    chk("def_done_px", px[0], 1);
    chk("def_done_tout", tout[0], 0);

    // GAP=0, WAIT_DONE=0: valid held with churning data, 5-cycle period
    send(1, plist[0]);
    tick();
    for (int n = 0; n < 3; n++) begin
      watch(1, 0, -1, 1);
      tick();
      chk($sformatf("nw_idle_ready_p%0d", n), ready[1], 1);
      chk($sformatf("nw_idle_busy_p%0d", n), busy[1], 0);
      chk($sformatf("nw_idle_start_p%0d", n), start[1], 0);
      chk($sformatf("nw_idle_rgb_p%0d", n), rgb[1], 0);
      chk($sformatf("nw_px_p%0d", n), px[1], n + 1);
      if (n < 2) begin
        send(1, plist[n + 1]);
        tick();
      end else begin
        valid[1] = 1'b0;
      end
    end
    tick();
    chk("nw_final_px", px[1], 3);
    chk("nw_final_busy", busy[1], 0);

    // TIMEOUT=4 with no done
    send(2, 24'h102030);
    tick();
    valid[2] = 1'b0;
    watch(2, 1, -1, 0);
    tick();
    chk("to_w1_busy", busy[2], 1);
    chk("to_w1_tout", tout[2], 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("to_w%0d_busy", i), busy[2], 1);
      chk($sformatf("to_w%0d_tout", i), tout[2], 0);
    end
    tick();
    chk("to_pulse", tout[2], 1);
    chk("to_busy", busy[2], 0);
    chk("to_ready", ready[2], 1);
    chk("to_px", px[2], 1);
    tick();
    chk("to_pulse_end", tout[2], 0);
    chk("to_px_hold", px[2], 1);

    // Done pulsed in START is ignored: times out again
    send(2, 24'h0A0B0C);
    tick();
    valid[2] = 1'b0;
    watch(2, 1, 0, 0);
    tick();
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("ign_w%0d_busy", i), busy[2], 1);
    end
    tick();
    chk("ign_pulse", tout[2], 1);
    chk("ign_px", px[2], 2);

    // Done coincident with timeout expiry counts as done
    send(2, 24'h0F0E0D);
    tick();
    valid[2] = 1'b0;
    watch(2, 1, -1, 0);
    tick();
    tick();
    tick();
    tick();
    dn[2] = 1'b1;
    tick();
    dn[2] = 1'b0;
    chk("coin_tout", tout[2], 0);
    chk("coin_busy", busy[2], 0);
    chk("coin_px", px[2], 3);
    tick();
    chk("to4_pulse_count", tout_cnt[2], 2);

    // Async reset in the SEND_G cycle
    pix[0]   = 24'h123456;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    chk("ar_start", start[0], 1);
    tick();
    tick();
    chk("ar_r", rgb[0], 10'h012);
    tick();
    chk("ar_g", rgb[0], 10'h034);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_start_clr", start[0], 0);
    chk("ar_rgb_clr", rgb[0], 0);
    chk("ar_busy_clr", busy[0], 0);
    chk("ar_px_clr", px[0], 0);
    chk("ar_ready_low", ready[0], 0);
    #2;
    rst = 1'b0;
    tick();
    chk("ar_rel_ready", ready[0], 1);
    chk("ar_rel_busy", busy[0], 0);

    // Next pixel after reset; done only in the SEND_B cycle
    send(0, 24'hABCDEF);
    tick();
    valid[0] = 1'b0;
    watch(0, 1, 4, 0);
    tick();
    dn[0] = 1'b0;
    chk("fast_wait_busy", busy[0], 1);
    tick();
    chk("fast_exit_busy", busy[0], 0);
    chk("fast_exit_px", px[0], 1);
    chk("fast_exit_tout", tout[0], 0);
    chk("def_no_timeouts", tout_cnt[0], 0);
    chk("sb_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pixel_serializer.md
Name: rgb_pixel_serializer

Overview:
- Producer side of the grayscale converter's channel-serial input protocol.
- Accepts one packed 24-bit RGB pixel per valid/ready handshake.
- Emits a one-cycle start pulse, then the R, G and B channels on consecutive cycles on a 10-bit colour bus.
- Optionally waits for the converter's result-valid before accepting the next pixel. Sits between the Avalon-side pixel fetch and the rgb-to-gray stage.

Parameters:
- CHAN_W, 8, width of each input colour channel.
- OUT_W, 10, width of serial colour bus; channels are zero-extended to this width; must be >= CHAN_W.
- GAP_CYCLES, 1, idle cycles between the start pulse and the R cycle; range 0..15.
- WAIT_DONE, 1, 1 = hold off the next pixel until dn_valid_i or timeout; 0 = return to IDLE right after B.
- TIMEOUT, 64, cycles to wait in WAIT before abandoning the pixel; range 1..65535.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- pix_valid_i  in  1  upstream pixel valid.
- pix_data_i  in  3*CHAN_W  packed pixel {R,G,B}; R in the MSBs.
- pix_ready_o  out  1  upstream ready.
- start_o  out  1  one-cycle start pulse to the converter.
- RgbColor_o  out  OUT_W  serial channel value.
- dn_valid_i  in  1  converter result valid.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  one-cycle pulse when the WAIT timeout expires.
- px_count_o  out  16  pixels completed (done or timed out); wraps at 65535->0.

Behaviour:
- Reset: state=IDLE, pix_ready_o=0 during reset and 1 from the first edge after release. All other outputs and the pixel register are 0. Reset is asynchronous and aborts any transfer mid-stream: start_o and RgbColor_o go to 0 immediately, px_count_o clears, and the in-flight pixel is dropped.
- All outputs are registered. pix_ready_o=1 only in IDLE.
- Accept: pix_valid_i && pix_ready_o at edge k latches pix_data_i and moves to START. Data presented while ready=0 is neither captured nor lost; upstream holds it.
- States and per-state outputs:
  - IDLE.
  - START: start_o=1, RgbColor_o=0; lasts exactly 1 cycle.
  - GAP: GAP_CYCLES cycles, RgbColor_o=0; skipped if GAP_CYCLES=0.
  - SEND_R: RgbColor_o = zero-extended R, 1 cycle.
  - SEND_G: RgbColor_o = zero-extended G, 1 cycle.
  - SEND_B: RgbColor_o = zero-extended B, 1 cycle.
  - WAIT: only if WAIT_DONE=1.
- Timing relative to accept edge k: start_o is high in the cycle after edge k. R appears GAP_CYCLES+1 cycles after start; G and B follow on the next two cycles. RgbColor_o is 0 in every cycle that is not R/G/B.
- WAIT_DONE=0: SEND_B -> IDLE; px_count_o increments on that transition. Minimum pixel period is GAP_CYCLES+5 cycles including the IDLE accept cycle.
- WAIT_DONE=1: a done flag is set if dn_valid_i is high during SEND_B, so a fast converter is not missed.
  - In WAIT, done flag or dn_valid_i -> IDLE and px_count_o increments.
  - Otherwise a 16-bit counter runs. When it reaches TIMEOUT, go to IDLE, pulse timeout_o for 1 cycle and increment px_count_o.
  - The counter and done flag clear when entering START.
- dn_valid_i in any other state is ignored.
- A timeout and dn_valid_i in the same cycle count as done: no timeout pulse.
- px_count_o increments exactly once per pixel.

Test Plan:
- Reset mid-SEND_G (assert rst_i between edges) -> start_o=0, RgbColor_o=0 and busy_o=0 immediately; px_count_o=0; after release the next pixel serializes normally.
- Defaults; pixel 0xEEEEEE accepted at edge k -> start_o=1 in cycle k+1; RgbColor_o=0 in cycle k+2; 10'd238 in cycles k+3, k+4, k+5. Raise dn_valid_i at k+8 -> IDLE, px_count_o=1, timeout_o never asserted.
- Pixel 0xFF0080, GAP_CYCLES=0, WAIT_DONE=0 -> RgbColor_o = 255, 0, 128 in the three cycles after start; pix_ready_o returns to 1 on the following cycle; back-to-back valid gives a 5-cycle pixel period.
- WAIT_DONE=1, TIMEOUT=4, dn_valid_i held 0 -> timeout_o pulses once 4 cycles after entering WAIT; px_count_o=1; next pixel is accepted.
- dn_valid_i pulsed only in the SEND_B cycle -> WAIT exits on the next edge with no timeout; dn_valid_i pulsed in START -> ignored and pixel times out.
- Hold pix_valid_i=1 with changing data while busy -> only the value present at each ready cycle is serialized; 3 pixels give px_count_o=3.
